// File: rtl/sram_1w1r_arbiter.sv
// Two-client round-robin arbiter in front of a 1W1R SRAM macro, with registered, id-tagged read data.
// Define SRAM_ARB_INIT_EN to zero-fill the whole array after every reset before traffic is accepted.
module sram_1w1r_arbiter #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 41,
  parameter int NUM_WMASKS = 5
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [1:0]                wr_req_i,
  input  logic [2*ADDR_WIDTH-1:0]   wr_addr_i,
  input  logic [2*NUM_WMASKS-1:0]   wr_wmask_i,
  input  logic [1:0]                wr_spare_i,
  input  logic [2*DATA_WIDTH-1:0]   wr_data_i,
  output logic [1:0]                wr_gnt_o,
  input  logic [1:0]                rd_req_i,
  input  logic [2*ADDR_WIDTH-1:0]   rd_addr_i,
  output logic [1:0]                rd_gnt_o,
  output logic                      rd_valid_o,
  output logic                      rd_id_o,
  output logic [DATA_WIDTH-1:0]     rd_data_o,
  output logic                      init_busy_o,
  output logic                      sram_csb0_o,
  output logic [NUM_WMASKS-1:0]     sram_wmask0_o,
  output logic                      sram_spare_wen0_o,
  output logic [ADDR_WIDTH-1:0]     sram_addr0_o,
  output logic [DATA_WIDTH-1:0]     sram_din0_o,
  output logic                      sram_csb1_o,
  output logic [ADDR_WIDTH-1:0]     sram_addr1_o,
  input  logic [DATA_WIDTH-1:0]     sram_dout1_i
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   init_cnt;

`ifdef SRAM_ARB_INIT_EN
  state_t state_next;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == ST_INIT) init_cnt <= init_cnt + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    if (state == ST_INIT && (&init_cnt)) state_next = ST_RUN;
  end
`else
  assign state    = ST_RUN;
  assign init_cnt = '0;
`endif

  logic run;
  assign run         = (state == ST_RUN);
  assign init_busy_o = (state == ST_INIT);

  // Winner per port: the lone requester, or the pointer's client when both ask.
  logic                  wr_ptr, rd_ptr;
  logic                  wr_win, rd_win;
  logic                  wr_go, rd_go, rd_blocked;
  logic [ADDR_WIDTH-1:0] wr_addr_sel, rd_addr_sel;

  assign wr_win      = (wr_req_i == 2'b11) ? wr_ptr : wr_req_i[1];
  assign rd_win      = (rd_req_i == 2'b11) ? rd_ptr : rd_req_i[1];
  assign wr_addr_sel = wr_win ? wr_addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : wr_addr_i[ADDR_WIDTH-1:0];
  assign rd_addr_sel = rd_win ? rd_addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : rd_addr_i[ADDR_WIDTH-1:0];

  // A read to the address being written this cycle would see stale data, so the write wins.
  assign wr_go      = run && (|wr_req_i);
  assign rd_blocked = wr_go && (rd_addr_sel == wr_addr_sel);
  assign rd_go      = run && (|rd_req_i) && !rd_blocked;

  assign wr_gnt_o = wr_go ? (wr_win ? 2'b10 : 2'b01) : 2'b00;
  assign rd_gnt_o = rd_go ? (rd_win ? 2'b10 : 2'b01) : 2'b00;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    sram_csb0_o       = 1'b1;
    sram_wmask0_o     = '0;
    sram_spare_wen0_o = 1'b0;
    sram_addr0_o      = wr_addr_sel;
    sram_din0_o       = wr_win ? wr_data_i[2*DATA_WIDTH-1:DATA_WIDTH] : wr_data_i[DATA_WIDTH-1:0];
    if (state == ST_INIT) begin
      sram_csb0_o       = 1'b0;
      sram_wmask0_o     = {NUM_WMASKS{1'b1}};
      sram_spare_wen0_o = 1'b1;
      sram_addr0_o      = init_cnt;
      sram_din0_o       = '0;
    end else if (wr_go) begin
      sram_csb0_o       = 1'b0;
      sram_wmask0_o     = wr_win ? wr_wmask_i[2*NUM_WMASKS-1:NUM_WMASKS] : wr_wmask_i[NUM_WMASKS-1:0];
      sram_spare_wen0_o = wr_win ? wr_spare_i[1] : wr_spare_i[0];
    end
  end

  assign sram_csb1_o  = !rd_go;
  assign sram_addr1_o = rd_addr_sel;

  // Read pipeline: the macro latches the address at acceptance, its output is registered one edge later.
  logic rd_pend, rd_pend_id;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      rd_pend    <= 1'b0;
      rd_pend_id <= 1'b0;
      rd_valid_o <= 1'b0;
      rd_id_o    <= 1'b0;
      rd_data_o  <= '0;
    end else begin
      if (wr_go) wr_ptr <= ~wr_win;
      if (rd_go) rd_ptr <= ~rd_win;
      rd_pend    <= rd_go;
      rd_pend_id <= rd_win;
      rd_valid_o <= rd_pend;
      if (rd_pend) begin
        rd_id_o   <= rd_pend_id;
        rd_data_o <= sram_dout1_i;
      end
    end
  end

endmodule

// File: tb/tb_sram_1w1r_arbiter.sv
// Directed bench for sram_1w1r_arbiter with a behavioural 512x41 SRAM and a response scoreboard.
// Build with +define+SRAM_ARB_INIT_EN to also exercise the init sweep.
module tb_sram_1w1r_arbiter;

  localparam int AW = 9;
  localparam int DW = 41;
  localparam int MW = 5;

  localparam logic [DW-1:0] W1  = 41'h1_23456789AB;
  localparam logic [DW-1:0] W1P = 41'h1_23456789FF;
  localparam logic [DW-1:0] W2  = 41'h0_CAFEF00D55;
  localparam logic [DW-1:0] W3  = 41'h1_0F0F0F0F0F;
`ifdef SRAM_ARB_INIT_EN
  localparam logic [DW-1:0] POST_RST_WORD = '0;
  localparam logic          INIT_AT_RESET = 1'b1;
`else
  localparam logic [DW-1:0] POST_RST_WORD = W1P;
  localparam logic          INIT_AT_RESET = 1'b0;
`endif

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [1:0]        wr_req_i;
  logic [2*AW-1:0]   wr_addr_i;
  logic [2*MW-1:0]   wr_wmask_i;
  logic [1:0]        wr_spare_i;
  logic [2*DW-1:0]   wr_data_i;
  logic [1:0]        wr_gnt_o;
  logic [1:0]        rd_req_i;
  logic [2*AW-1:0]   rd_addr_i;
  logic [1:0]        rd_gnt_o;
  logic              rd_valid_o;
  logic              rd_id_o;
  logic [DW-1:0]     rd_data_o;
  logic              init_busy_o;
  logic              sram_csb0_o;
  logic [MW-1:0]     sram_wmask0_o;
  logic              sram_spare_wen0_o;
  logic [AW-1:0]     sram_addr0_o;
  logic [DW-1:0]     sram_din0_o;
  logic              sram_csb1_o;
  logic [AW-1:0]     sram_addr1_o;
  logic [DW-1:0]     sram_dout1_i;

  sram_1w1r_arbiter dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .wr_req_i(wr_req_i), .wr_addr_i(wr_addr_i), .wr_wmask_i(wr_wmask_i),
    .wr_spare_i(wr_spare_i), .wr_data_i(wr_data_i), .wr_gnt_o(wr_gnt_o),
    .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_gnt_o(rd_gnt_o),
    .rd_valid_o(rd_valid_o), .rd_id_o(rd_id_o), .rd_data_o(rd_data_o),
    .init_busy_o(init_busy_o),
    .sram_csb0_o(sram_csb0_o), .sram_wmask0_o(sram_wmask0_o),
    .sram_spare_wen0_o(sram_spare_wen0_o), .sram_addr0_o(sram_addr0_o),
    .sram_din0_o(sram_din0_o), .sram_csb1_o(sram_csb1_o),
    .sram_addr1_o(sram_addr1_o), .sram_dout1_i(sram_dout1_i)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural 1W1R macro: byte-masked write, spare bit 40, registered read of the pre-edge contents.
  logic [DW-1:0] mem [1<<AW];
  always @(posedge clk_i) begin
    if (!sram_csb0_o) begin
      for (int b = 0; b < MW; b++)
        if (sram_wmask0_o[b]) mem[sram_addr0_o][8*b +: 8] <= sram_din0_o[8*b +: 8];
      if (sram_spare_wen0_o) mem[sram_addr0_o][40] <= sram_din0_o[40];
    end
    if (!sram_csb1_o) sram_dout1_i <= mem[sram_addr1_o];
  end

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic          id;
    logic [DW-1:0] data;
    int            due;
  } exp_t;
  exp_t sb[$];

  // Called at the negedge of the grant cycle: the response is due two cycles later.
  task automatic expect_rsp(input logic id, input logic [DW-1:0] data);
    exp_t e;
    e.id   = id;
    e.data = data;
    e.due  = cyc + 2;
    sb.push_back(e);
  endtask

  always @(negedge clk_i) begin
    if (rst_ni && rd_valid_o) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", {63'd0, rd_valid_o}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_id", {63'd0, rd_id_o}, {63'd0, e.id});
        check("rsp_data", {23'd0, rd_data_o}, {23'd0, e.data});
        check("rsp_latency", 64'(cyc), 64'(e.due));
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clr();
    wr_req_i = '0; rd_req_i = '0;
  endtask

  task automatic set_wr(input int c, input logic [AW-1:0] a, input logic [MW-1:0] m,
                        input logic s, input logic [DW-1:0] d);
    wr_addr_i[c*AW +: AW]  = a;
    wr_wmask_i[c*MW +: MW] = m;
    wr_spare_i[c]          = s;
    wr_data_i[c*DW +: DW]  = d;
  endtask

  task automatic set_rd(input int c, input logic [AW-1:0] a);
    rd_addr_i[c*AW +: AW] = a;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      step();
      n++;
    end
    check("drain_outstanding", 64'(sb.size()), 64'd0);
  endtask

  task automatic wait_init(input bit detailed);
`ifdef SRAM_ARB_INIT_EN
    if (detailed) begin
      wr_req_i = 2'b11; rd_req_i = 2'b11;
      for (int i = 0; i < (1 << AW); i++) begin
        @(negedge clk_i);
        check("init_busy", {63'd0, init_busy_o}, 64'd1);
        check("init_addr", {55'd0, sram_addr0_o}, 64'(i));
        check("init_csb0", {63'd0, sram_csb0_o}, 64'd0);
        check("init_no_gnt", {60'd0, wr_gnt_o, rd_gnt_o}, 64'd0);
        step();
      end
      clr();
    end else begin
      int n = 0;
      while (init_busy_o && n < 600) begin
        step();
        n++;
      end
    end
`endif
    @(negedge clk_i);
    check("init_busy_done", {63'd0, init_busy_o}, 64'd0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0;
    wr_addr_i = '0; wr_wmask_i = '0; wr_spare_i = '0; wr_data_i = '0; rd_addr_i = '0;
    clr();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_valid", {63'd0, rd_valid_o}, 64'd0);
    check("rst_id", {63'd0, rd_id_o}, 64'd0);
    check("rst_data", {23'd0, rd_data_o}, 64'd0);
    check("rst_busy", {63'd0, init_busy_o}, {63'd0, INIT_AT_RESET});
    check("rst_csb1", {63'd0, sram_csb1_o}, 64'd1);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    wait_init(1'b1);

    // Single write by client 0, then read by client 1
    set_wr(0, 9'h05, 5'h1F, 1'b1, W1);
    wr_req_i = 2'b01;
    @(negedge clk_i);
    check("w1_gnt", {62'd0, wr_gnt_o}, 64'h1);
    check("w1_csb0", {63'd0, sram_csb0_o}, 64'd0);
    check("w1_addr0", {55'd0, sram_addr0_o}, 64'h05);
    check("w1_din0", {23'd0, sram_din0_o}, {23'd0, W1});
    check("w1_wmask0", {59'd0, sram_wmask0_o}, 64'h1F);
    check("w1_spare0", {63'd0, sram_spare_wen0_o}, 64'd1);
    check("w1_csb1", {63'd0, sram_csb1_o}, 64'd1);
    step();
    wr_req_i = 2'b00;
    set_rd(1, 9'h05);
    rd_req_i = 2'b10;
    @(negedge clk_i);
    check("r1_gnt", {62'd0, rd_gnt_o}, 64'h2);
    check("r1_csb1", {63'd0, sram_csb1_o}, 64'd0);
    check("r1_addr1", {55'd0, sram_addr1_o}, 64'h05);
    check("r1_csb0_idle", {63'd0, sram_csb0_o}, 64'd1);
    check("r1_wmask0_idle", {59'd0, sram_wmask0_o}, 64'd0);
    expect_rsp(1'b1, W1);
    step();
    clr();
    drain();

    // Both clients write; write pointer now favours client 1
    set_wr(0, 9'h06, 5'h1F, 1'b1, W2);
    set_wr(1, 9'h05, 5'h01, 1'b0, 41'hFF);
    wr_req_i = 2'b11;
    @(negedge clk_i);
    check("w2_gnt_c1", {62'd0, wr_gnt_o}, 64'h2);
    check("w2_addr0", {55'd0, sram_addr0_o}, 64'h05);
    check("w2_wmask0", {59'd0, sram_wmask0_o}, 64'h01);
    check("w2_spare0", {63'd0, sram_spare_wen0_o}, 64'd0);
    step();
    wr_req_i = 2'b01;
    @(negedge clk_i);
    check("w2_gnt_c0", {62'd0, wr_gnt_o}, 64'h1);
    check("w2_addr0_c0", {55'd0, sram_addr0_o}, 64'h06);
    step();
    wr_req_i = 2'b00;
    set_rd(1, 9'h05);
    rd_req_i = 2'b10;
    @(negedge clk_i);
    check("r2_gnt", {62'd0, rd_gnt_o}, 64'h2);
    expect_rsp(1'b1, W1P);
    step();
    clr();
    drain();

    // Fairness: both readers held for four cycles
    set_rd(0, 9'h05);
    set_rd(1, 9'h06);
    rd_req_i = 2'b11;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      check("fair_gnt", {62'd0, rd_gnt_o}, (k % 2 == 0) ? 64'h1 : 64'h2);
      if (k % 2 == 0) expect_rsp(1'b0, W1P);
      else            expect_rsp(1'b1, W2);
      step();
    end
    clr();
    drain();

    // Collision: write 0x1A blocks the client-0 read of 0x1A; read pointer must hold
    set_wr(0, 9'h1A, 5'h1F, 1'b1, W3);
    wr_req_i = 2'b01;
    set_rd(0, 9'h1A);
    set_rd(1, 9'h1A);
    rd_req_i = 2'b11;
    @(negedge clk_i);
    check("col_wr_gnt", {62'd0, wr_gnt_o}, 64'h1);
    check("col_rd_gnt", {62'd0, rd_gnt_o}, 64'h0);
    check("col_csb1", {63'd0, sram_csb1_o}, 64'd1);
    check("col_csb0", {63'd0, sram_csb0_o}, 64'd0);
    step();
    wr_req_i = 2'b00;
    @(negedge clk_i);
    check("col_retry_gnt", {62'd0, rd_gnt_o}, 64'h1);
    check("col_retry_csb1", {63'd0, sram_csb1_o}, 64'd0);
    expect_rsp(1'b0, W3);
    step();
    rd_req_i = 2'b10;
    @(negedge clk_i);
    check("col_next_gnt", {62'd0, rd_gnt_o}, 64'h2);
    expect_rsp(1'b1, W3);
    step();
    clr();
    drain();

    // Reset while a response is in flight; pointers were left at wr=1, rd=1
    set_rd(0, 9'h05);
    rd_req_i = 2'b01;
    @(negedge clk_i);
    check("rst_pre_gnt", {62'd0, rd_gnt_o}, 64'h1);
    step();
    clr();
    step();
    rst_ni = 1'b0;
    #1;
    check("rst_valid_drop", {63'd0, rd_valid_o}, 64'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_i);
      check("rst_valid_hold", {63'd0, rd_valid_o}, 64'd0);
    end
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    wait_init(1'b0);
    set_wr(0, 9'h30, 5'h1F, 1'b1, W2);
    set_wr(1, 9'h31, 5'h1F, 1'b1, W2);
    wr_req_i = 2'b11;
    set_rd(0, 9'h05);
    set_rd(1, 9'h05);
    rd_req_i = 2'b11;
    @(negedge clk_i);
    check("post_rst_wr_gnt", {62'd0, wr_gnt_o}, 64'h1);
    check("post_rst_rd_gnt", {62'd0, rd_gnt_o}, 64'h1);
    expect_rsp(1'b0, POST_RST_WORD);
    step();
    wr_req_i = 2'b10;
    rd_req_i = 2'b10;
    @(negedge clk_i);
    check("post_rst_wr_gnt2", {62'd0, wr_gnt_o}, 64'h2);
    check("post_rst_rd_gnt2", {62'd0, rd_gnt_o}, 64'h2);
    expect_rsp(1'b1, POST_RST_WORD);
    step();
    clr();
    drain();

`ifdef SRAM_ARB_INIT_EN
    // Top address was zero-filled by the sweep
    set_rd(0, 9'h1FF);
    rd_req_i = 2'b01;
    @(negedge clk_i);
    check("init_rd_gnt", {62'd0, rd_gnt_o}, 64'h1);
    expect_rsp(1'b0, '0);
    step();
    clr();
    drain();
`endif

    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_1w1r_arbiter.md
Name: sram_1w1r_arbiter

Overview:
- Shares one 512x41 1W1R SRAM macro (one write port, one read port) between two requesters.
- Runs independent round-robin arbitration on each port and blocks a read that hits the same address as a same-cycle write.
- Returns read data registered, tagged with the requester id.
- Sits between the SRAM macro and its two clients (e.g. fetch-side and data-side).

Parameters:
ADDR_WIDTH, 9, SRAM word address width (RAM_DEPTH = 1<<ADDR_WIDTH)
DATA_WIDTH, 41, SRAM word width: 40 data bits plus 1 spare bit
NUM_WMASKS, 5, byte write-enable count covering bits [39:0]

Ports:
clk_i  in  1  clock; also drives SRAM clk0 and clk1
rst_ni  in  1  asynchronous active-low reset
wr_req_i  in  2  per-client write request; held until granted
wr_addr_i  in  2*ADDR_WIDTH  per-client write address, client n at slice n
wr_wmask_i  in  2*NUM_WMASKS  per-client byte mask
wr_spare_i  in  2  per-client spare-bit write enable
wr_data_i  in  2*DATA_WIDTH  per-client write data
wr_gnt_o  out  2  write accepted this cycle, one-hot or zero
rd_req_i  in  2  per-client read request; held until granted
rd_addr_i  in  2*ADDR_WIDTH  per-client read address
rd_gnt_o  out  2  read accepted this cycle, one-hot or zero
rd_valid_o  out  1  read response valid
rd_id_o  out  1  client index of the response
rd_data_o  out  DATA_WIDTH  read response data
init_busy_o  out  1  init sweep in progress (see Optional Feature)
sram_csb0_o  out  1  SRAM write chip select, active low
sram_wmask0_o  out  NUM_WMASKS  SRAM byte mask
sram_spare_wen0_o  out  1  SRAM spare-bit write enable
sram_addr0_o  out  ADDR_WIDTH  SRAM write address
sram_din0_o  out  DATA_WIDTH  SRAM write data
sram_csb1_o  out  1  SRAM read chip select, active low
sram_addr1_o  out  ADDR_WIDTH  SRAM read address
sram_dout1_i  in  DATA_WIDTH  SRAM read data

Behaviour:
- Reset values: rd_valid_o=0, rd_id_o=0, rd_data_o=0, both round-robin pointers=0 (client 0 preferred), init_busy_o per the Optional Feature.
- Handshake: a request is accepted on the rising edge where req and gnt are both 1. Grants are combinational from the current requests and state. A client may drop or change its request only after acceptance.
- Round-robin, per port, independently:
  - single requester: it wins;
  - both request: the client indicated by that port's pointer wins;
  - on acceptance the pointer moves to the other client.
- SRAM drive, combinational from the winner:
  - write port: sram_csb0_o=0 only when a write is granted. Addr, wmask, spare and data come from the winner; otherwise csb0=1, wmask=0, spare=0.
  - read port: sram_csb1_o=0 only when a read is granted. sram_addr1_o comes from the winner.
- Collision rule: if both ports would grant in one cycle and the winning addresses are equal:
  - the write is granted;
  - rd_gnt_o is forced to 0;
  - the read pointer does not advance;
  - the read retries next cycle.
- Read latency:
  - a read accepted at edge E0 is latched by the SRAM at E0;
  - sram_dout1_i is captured into rd_data_o at E1;
  - rd_valid_o=1 and rd_id_o=winner are driven for exactly the cycle following E1.
  - Back-to-back reads give one response per cycle, in order.
- Read-after-write: a write accepted at E0 is visible to any read accepted at E1 or later.
- Reset asserted mid-operation: in-flight responses are dropped and rd_valid_o=0 immediately.

Optional Feature:
Macro SRAM_ARB_INIT_EN.
- Defined:
  - after reset release, an INIT state writes every address 0..RAM_DEPTH-1, one per cycle;
  - each write uses data 0, wmask all ones, spare_wen=1;
  - init_busy_o=1 from reset through the cycle of the last write;
  - all wr_gnt_o/rd_gnt_o are 0 during INIT, then the FSM moves to RUN;
  - reset during INIT restarts the sweep at address 0.
- Not defined: the FSM starts in RUN, init_busy_o is tied 0, and SRAM contents stay uninitialised.

Test Plan:
- Single write then read: client0 writes addr 0x05, data 0x1_23456789AB, wmask 5'h1F, spare=1. Client1 reads 0x05 next cycle -> rd_valid_o two cycles after read acceptance, rd_id_o=1, rd_data_o=0x1_23456789AB.
- Partial write: client1 writes wmask 5'h01, data 0xFF to addr 0x05 (prior word above), then reads it -> rd_data_o=0x1_23456789FF.
- Fairness: both clients hold rd_req_i continuously for 4 cycles -> rd_gnt_o sequence 01,10,01,10; responses return rd_id_o 0,1,0,1.
- Collision: write addr 0x1A and read addr 0x1A in the same cycle -> wr_gnt_o set, rd_gnt_o=0, sram_csb1_o=1; the read is granted next cycle and returns the new data.
- Reset mid-traffic: assert rst_ni low one cycle after a read acceptance -> rd_valid_o stays 0, pointers return to 0, first post-reset conflict is won by client 0.
- Init sweep (SRAM_ARB_INIT_EN): after reset, init_busy_o=1 for 512 cycles with sram_addr0_o counting 0..511 and no grants. A later read of 0x1FF returns 0.
